alu_step_sequencer: RTL

- Multi-cycle successor to the single-cycle ALU function decoder, for the multi-cycle CPU where one shared ALU serves PC increment, execute, address calculation and branch work.
- Accepts one instruction per valid/ready handshake and issues an ordered sequence of ALU steps: function code plus operand-source selects, one step per accepted handshake with the datapath.
- Sits between the instruction register and the datapath operand muxes / ALU.

---
 rtl/alu_step_pkg.sv | 42 ++++
 rtl/alu_step_sequencer_rom.sv | 65 ++++++
 rtl/alu_step_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_step_pkg.sv
// Shared encodings for the ALU step sequencer: opcodes, ALU functions,
// operand-source selects and step kinds.
package alu_step_pkg;

   localparam logic [3:0] OP_BNE    = 4'd0;
   localparam logic [3:0] OP_BEQ    = 4'd1;
   localparam logic [3:0] OP_BGZ    = 4'd2;
   localparam logic [3:0] OP_BLZ    = 4'd3;
   localparam logic [3:0] OP_ADI    = 4'd4;
   localparam logic [3:0] OP_ORI    = 4'd5;
   localparam logic [3:0] OP_LHI    = 4'd6;
   localparam logic [3:0] OP_LWD    = 4'd7;
   localparam logic [3:0] OP_SWD    = 4'd8;
   localparam logic [3:0] OP_JMP    = 4'd9;
   localparam logic [3:0] OP_JAL    = 4'd10;
   localparam logic [3:0] OP_ALU_OP = 4'd15;

   localparam logic [2:0] FUNC_ADD = 3'd0;
   localparam logic [2:0] FUNC_SUB = 3'd1;
   localparam logic [2:0] FUNC_AND = 3'd2;
   localparam logic [2:0] FUNC_ORR = 3'd3;
   localparam logic [2:0] FUNC_NOT = 3'd4;
   localparam logic [2:0] FUNC_TCP = 3'd5;
   localparam logic [2:0] FUNC_SHL = 3'd6;
   localparam logic [2:0] FUNC_SHR = 3'd7;

   localparam logic [1:0] SRC_A_RS   = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;

   localparam logic [1:0] SRC_B_RT   = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_ONE  = 2'd2;
   localparam logic [1:0] SRC_B_ZERO = 2'd3;

   localparam logic [2:0] STEP_PC_INC = 3'd0;
   localparam logic [2:0] STEP_EXEC   = 3'd1;
   localparam logic [2:0] STEP_ADDR   = 3'd2;
   localparam logic [2:0] STEP_CMP    = 3'd3;
   localparam logic [2:0] STEP_TGT    = 3'd4;

endpackage

// File: rtl/alu_step_sequencer_rom.sv
// Combinational step table: (opcode, function field, step index) gives the
// ALU function, operand selects, step kind and whether this is the last step.
module alu_step_sequencer_rom
   import alu_step_pkg::*;
#(
   parameter int FUNC_W = 3
) (
   input  logic [3:0]        opcode,
   input  logic [FUNC_W-1:0] func_field,
   input  logic [1:0]        step_idx,
   output logic [FUNC_W-1:0] func,
   output logic [1:0]        src_a,
   output logic [1:0]        src_b,
   output logic [2:0]        kind,
   output logic              last
);

   always_comb begin
      func  = FUNC_W'(FUNC_ADD);
      src_a = SRC_A_PC;
      src_b = SRC_B_ONE;
      kind  = STEP_PC_INC;
      last  = 1'b1;
      case (step_idx)
         2'd0: begin
            // Every instruction starts with PC increment; only single-step opcodes end here.
            case (opcode)
               OP_ALU_OP, OP_ADI, OP_ORI, OP_LWD, OP_SWD,
               OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: last = 1'b0;
               default:                        last = 1'b1;
            endcase
         end
         2'd1: begin
            case (opcode)
               OP_ALU_OP: begin
                  func = func_field; src_a = SRC_A_RS; src_b = SRC_B_RT; kind = STEP_EXEC;
               end
               OP_ADI: begin
                  func = FUNC_W'(FUNC_ADD); src_a = SRC_A_RS; src_b = SRC_B_IMM; kind = STEP_EXEC;
               end
               OP_ORI: begin
                  func = FUNC_W'(FUNC_ORR); src_a = SRC_A_RS; src_b = SRC_B_IMM; kind = STEP_EXEC;
               end
               OP_LWD, OP_SWD: begin
                  func = FUNC_W'(FUNC_ADD); src_a = SRC_A_RS; src_b = SRC_B_IMM; kind = STEP_ADDR;
               end
               OP_BNE, OP_BEQ: begin
                  func = FUNC_W'(FUNC_SUB); src_a = SRC_A_RS; src_b = SRC_B_RT; kind = STEP_CMP;
                  last = 1'b0;
               end
               OP_BGZ, OP_BLZ: begin
                  func = FUNC_W'(FUNC_SUB); src_a = SRC_A_RS; src_b = SRC_B_ZERO; kind = STEP_CMP;
                  last = 1'b0;
               end
               default: ;
            endcase
         end
         2'd2: begin
            func = FUNC_W'(FUNC_ADD); src_a = SRC_A_PC; src_b = SRC_B_IMM; kind = STEP_TGT;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_step_sequencer.sv
// Multi-cycle ALU step sequencer: latches one instruction and issues its ALU
// steps over a valid/ready handshake. Optional retire counter: ALU_STEP_RETIRE_CNT_EN.
module alu_step_sequencer
   import alu_step_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int FUNC_W  = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic               step_valid,
   input  logic               step_ready,
   output logic [FUNC_W-1:0]  alu_func,
   output logic [1:0]         src_a,
   output logic [1:0]         src_b,
   output logic [2:0]         step_kind,
`ifdef ALU_STEP_RETIRE_CNT_EN
   input  logic               retire_clr,
   output logic [CNT_W-1:0]   retire_cnt,
`endif
   output logic               done
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]         state_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic [1:0]         step_idx_reg;
   logic               last_reg;

   logic [3:0]         rom_opcode;
   logic [FUNC_W-1:0]  rom_func_field;
   logic [1:0]         rom_idx;
   logic [FUNC_W-1:0]  rom_func;
   logic [1:0]         rom_src_a;
   logic [1:0]         rom_src_b;
   logic [2:0]         rom_kind;
   logic               rom_last;
   logic               unused_instr_bits;

   assign instr_ready       = (state_reg == ST_IDLE);
   assign unused_instr_bits = ^instr_reg[INSTR_W-5:FUNC_W];

   // In IDLE the table looks up step 0 of the incoming word; in ISSUE the next step of the latched one.
   always_comb begin
      if (state_reg == ST_IDLE) begin
         rom_opcode     = instr[INSTR_W-1 -: 4];
         rom_func_field = instr[FUNC_W-1:0];
         rom_idx        = 2'd0;
      end else begin
         rom_opcode     = instr_reg[INSTR_W-1 -: 4];
         rom_func_field = instr_reg[FUNC_W-1:0];
         rom_idx        = step_idx_reg + 2'd1;
      end
   end

   alu_step_sequencer_rom #(.FUNC_W(FUNC_W)) u_rom (
      .opcode     (rom_opcode),
      .func_field (rom_func_field),
      .step_idx   (rom_idx),
      .func       (rom_func),
      .src_a      (rom_src_a),
      .src_b      (rom_src_b),
      .kind       (rom_kind),
      .last       (rom_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         instr_reg    <= '0;
         step_idx_reg <= 2'd0;
         last_reg     <= 1'b0;
         step_valid   <= 1'b0;
         done         <= 1'b0;
         alu_func     <= '0;
         src_a        <= 2'd0;
         src_b        <= 2'd0;
         step_kind    <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (instr_valid) begin
                  instr_reg    <= instr;
                  step_idx_reg <= 2'd0;
                  last_reg     <= rom_last;
                  step_valid   <= 1'b1;
                  alu_func     <= rom_func;
                  src_a        <= rom_src_a;
                  src_b        <= rom_src_b;
                  step_kind    <= rom_kind;
                  state_reg    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (step_valid && step_ready) begin
                  if (last_reg) begin
                     done       <= 1'b1;
                     step_valid <= 1'b0;
                     alu_func   <= '0;
                     src_a      <= 2'd0;
                     src_b      <= 2'd0;
                     step_kind  <= 3'd0;
                     state_reg  <= ST_IDLE;
                  end else begin
                     step_idx_reg <= rom_idx;
                     last_reg     <= rom_last;
                     alu_func     <= rom_func;
                     src_a        <= rom_src_a;
                     src_b        <= rom_src_b;
                     step_kind    <= rom_kind;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_STEP_RETIRE_CNT_EN
   // Clear takes priority over the increment from a coincident done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retire_cnt <= '0;
      end else if (retire_clr) begin
         retire_cnt <= '0;
      end else if (done) begin
         retire_cnt <= retire_cnt + 1'b1;
      end
   end
`endif

endmodule
